// File: rtl/pcpi_sched_pkg.sv
// pcpi_sched_pkg: shared encodings for the PCPI scheduler and the core decoder
package pcpi_sched_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_e;
   localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;
   localparam logic [6:0] OPCODE_REG = 7'b0110011;
   localparam logic SLOT_MUL = 1'b0;
   localparam logic SLOT_DIV = 1'b1;
   function automatic logic is_muldiv(input logic [31:0] insn);
      return insn[31:25] == MULDIV_FUNCT7;
   endfunction
endpackage

// File: rtl/pcpi_sched_if.sv
// pcpi_sched_if: core-side PCPI port plus the mul and div slot ports
interface pcpi_sched_if;
   logic        pcpi_valid, pcpi_abort, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_fault;
   logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd, op_count;
   logic        mul_valid, mul_wr, mul_wait, mul_ready;
   logic        div_valid, div_wr, div_wait, div_ready;
   logic [31:0] mul_insn, mul_rs1, mul_rs2, mul_rd;
   logic [31:0] div_insn, div_rs1, div_rs2, div_rd;
   modport slave (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_abort,
             mul_wr, mul_rd, mul_wait, mul_ready, div_wr, div_rd, div_wait, div_ready,
      output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, pcpi_fault, op_count,
             mul_valid, mul_insn, mul_rs1, mul_rs2, div_valid, div_insn, div_rs1, div_rs2
   );
   modport master (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_abort,
             mul_wr, mul_rd, mul_wait, mul_ready, div_wr, div_rd, div_wait, div_ready,
      input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, pcpi_fault, op_count,
             mul_valid, mul_insn, mul_rs1, mul_rs2, div_valid, div_insn, div_rs1, div_rs2
   );
endinterface

// File: rtl/pcpi_sched_timeout.sv
// pcpi_timeout: no-response counter, cleared on capture, stops at its last value
module pcpi_timeout #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   input  logic frz_i,
   output logic expire_o
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (en_i && !frz_i && cnt_q != LAST) ? cnt_q + CNT_W'(1) : cnt_q;
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign expire_o = en_i && cnt_q == LAST;
endmodule

// File: rtl/pcpi_sched.sv
// pcpi_sched: routes PCPI M-extension ops to the mul or div slot with timeout and fault return
module pcpi_sched
   import pcpi_sched_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W = 5
) (
   input logic clk,
   input logic reset,
   pcpi_sched_if.slave bus
);
   state_e state_q, state_d;
   logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, op_count_q, op_count_d;
   logic sel_q, sel_d, wait_seen_q, wait_seen_d;
   logic capture, busy, sel_ready, sel_wait, sel_wr, expire, done, tmo, fault, rdy, ok;
   logic [31:0] sel_rd;
   assign capture   = state_q == IDLE && bus.pcpi_valid && !bus.pcpi_abort;
   assign busy      = state_q == BUSY;
   assign sel_ready = sel_q == SLOT_DIV ? bus.div_ready : bus.mul_ready;
   assign sel_wait  = sel_q == SLOT_DIV ? bus.div_wait : bus.mul_wait;
   assign sel_wr    = sel_q == SLOT_DIV ? bus.div_wr : bus.mul_wr;
   assign sel_rd    = sel_q == SLOT_DIV ? bus.div_rd : bus.mul_rd;
   pcpi_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
      .clk(clk), .reset(reset), .clr_i(capture), .en_i(busy),
      .frz_i(wait_seen_q || sel_wait), .expire_o(expire)
   );
   // ready wins over a same-cycle timeout; abort suppresses both
   assign done  = busy && sel_ready;
   assign tmo   = busy && !sel_ready && !wait_seen_q && expire;
   assign fault = state_q == DRAIN || tmo;
   assign rdy   = !bus.pcpi_abort && (done || fault);
   assign ok    = rdy && !fault;
   always_comb begin
      state_d     = bus.pcpi_abort ? IDLE : capture ? (is_muldiv(bus.pcpi_insn) ? BUSY : DRAIN) : rdy ? IDLE : state_q;
      insn_d      = capture ? bus.pcpi_insn : insn_q;
      rs1_d       = capture ? bus.pcpi_rs1 : rs1_q;
      rs2_d       = capture ? bus.pcpi_rs2 : rs2_q;
      sel_d       = capture ? bus.pcpi_insn[14] : sel_q;
      wait_seen_d = capture ? 1'b0 : (busy && sel_wait) ? 1'b1 : wait_seen_q;
      op_count_d  = (ok && op_count_q != '1) ? op_count_q + 32'd1 : op_count_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         insn_q      <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         sel_q       <= SLOT_MUL;
         wait_seen_q <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         insn_q      <= insn_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         sel_q       <= sel_d;
         wait_seen_q <= wait_seen_d;
         op_count_q  <= op_count_d;
      end
   end
   assign bus.mul_valid  = busy && sel_q == SLOT_MUL;
   assign bus.div_valid  = busy && sel_q == SLOT_DIV;
   assign bus.mul_insn   = insn_q;
   assign bus.mul_rs1    = rs1_q;
   assign bus.mul_rs2    = rs2_q;
   assign bus.div_insn   = insn_q;
   assign bus.div_rs1    = rs1_q;
   assign bus.div_rs2    = rs2_q;
   assign bus.pcpi_ready = rdy;
   assign bus.pcpi_fault = rdy && fault;
   assign bus.pcpi_wr    = ok && sel_wr;
   assign bus.pcpi_rd    = ok ? sel_rd : '0;
   assign bus.pcpi_wait  = busy && wait_seen_q;
   assign bus.op_count   = op_count_q;
endmodule
